// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and encodings.
// Used by the hazard controller and its helpers.
package riscv_pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MWAIT = 2'b01,
    ST_ERR   = 2'b10
  } hz_state_t;

  // M-stage result wins over W-stage result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (Clr)
      count_d = '0;
    else if (Inc && (count_q != '1))
      count_d = count_q + W'(1);
  end

  // Count register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign Count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use,
// branch flush and data-memory wait sequencing.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic             MemReq_M,
  input  logic             MemReady,
  input  logic             CntClear,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       Forward_AE,
  output logic [1:0]       Forward_BE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TO_VAL = WCW'(TIMEOUT);

  hz_state_t      state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           err_q, err_d;
  logic           lw;
  logic           ms;

  // Operand forwarding selects for EX.
  always_comb begin
    Forward_AE = fwd_sel(Rs1_E, Rd_M, RegWrite_M,
                         Rd_W, RegWrite_W);
    Forward_BE = fwd_sel(Rs2_E, Rd_M, RegWrite_M,
                         Rd_W, RegWrite_W);
  end

  // Stall/flush decode; a memory wait freezes everything
  // and defers any pending branch flush.
  always_comb begin
    lw = (ResultSrc_E == RES_MEM) && (Rd_E != 5'd0) &&
         ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    ms = (MemReq_M && !MemReady) || (state_q == ST_ERR);
    Stall_F = lw;
    Stall_D = lw;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = PCSrc_E;
    Flush_E = lw | PCSrc_E;
    Flush_W = 1'b0;
    if (ms) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_D = 1'b0;
      Flush_E = 1'b0;
      Flush_W = 1'b1;
    end
  end

  // Memory wait FSM next-state with timeout.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (MemReq_M && !MemReady) begin
          state_d = ST_MWAIT;
          wcnt_d  = WCW'(1);
        end
      end
      ST_MWAIT: begin
        if (MemReady) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if ((TIMEOUT != 0) &&
                     (wcnt_q == TO_VAL)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign MemErr = err_q;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (CntClear),
    .Inc   (Stall_F),
    .Count (StallCount)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (CntClear),
    .Inc   (Flush_D),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// TIMEOUT=4, CNT_W=3 to reach timeout and saturation.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E;
  logic [4:0] Rd_M, Rd_W;
  logic       RegWrite_M, RegWrite_W;
  logic [1:0] ResultSrc_E;
  logic       PCSrc_E, MemReq_M, MemReady, CntClear;
  logic       Stall_F, Stall_D, Stall_E, Stall_M;
  logic       Flush_D, Flush_E, Flush_W;
  logic [1:0] Forward_AE, Forward_BE;
  logic       MemErr;
  logic [2:0] StallCount, FlushCount;

  int n_run  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rs1_E       (Rs1_E),
    .Rs2_E       (Rs2_E),
    .Rd_E        (Rd_E),
    .Rd_M        (Rd_M),
    .Rd_W        (Rd_W),
    .RegWrite_M  (RegWrite_M),
    .RegWrite_W  (RegWrite_W),
    .ResultSrc_E (ResultSrc_E),
    .PCSrc_E     (PCSrc_E),
    .MemReq_M    (MemReq_M),
    .MemReady    (MemReady),
    .CntClear    (CntClear),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Stall_M     (Stall_M),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .Flush_W     (Flush_W),
    .Forward_AE  (Forward_AE),
    .Forward_BE  (Forward_BE),
    .MemErr      (MemErr),
    .StallCount  (StallCount),
    .FlushCount  (FlushCount)
  );

  always #5 Clk = ~Clk;

  logic lw_tb;
  assign lw_tb = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                 ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always @(negedge Clk)
    if (!Reset)
      assert (!(lw_tb && PCSrc_E))
        else $error("load-use and branch overlap");

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0;
    Rd_M = 0; Rd_W = 0; RegWrite_M = 0; RegWrite_W = 0;
    ResultSrc_E = 2'b00; PCSrc_E = 0; MemReq_M = 0;
    MemReady = 0; CntClear = 0;
  endtask

  // {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,Flush_W}
  function automatic logic [6:0] ctl();
    return {Stall_F, Stall_D, Stall_E, Stall_M,
            Flush_D, Flush_E, Flush_W};
  endfunction

  initial begin
    idle();
    Reset = 1'b1;
    #12;
    chk("rst_ctl", ctl(), 7'b0);
    chk("rst_fwd", {Forward_AE, Forward_BE}, 4'b0);
    chk("rst_err", MemErr, 1'b0);
    chk("rst_cnt", {StallCount, FlushCount}, 6'd0);
    Reset = 1'b0;
    step();

    // Forwarding.
    RegWrite_M = 1; Rd_M = 5; RegWrite_W = 1; Rd_W = 5;
    Rs1_E = 5; Rs2_E = 3;
    #1 chk("fwd_m", {Forward_AE, Forward_BE}, 4'b1000);
    Rd_M = 6; Rs2_E = 5;
    #1 chk("fwd_w", {Forward_AE, Forward_BE}, 4'b0101);
    Rd_M = 0; Rd_W = 0; Rs1_E = 0; Rs2_E = 0;
    #1 chk("fwd_x0", {Forward_AE, Forward_BE}, 4'b0000);
    RegWrite_M = 0; Rd_M = 9; Rs1_E = 9;
    #1 chk("fwd_nowe", Forward_AE, 2'b00);
    idle();

    // Load-use.
    step();
    ResultSrc_E = 2'b01; Rd_E = 7; Rs1_D = 7;
    #1 chk("lw_ctl", ctl(), 7'b1100010);
    step();
    idle();
    #1 chk("lw_after", ctl(), 7'b0);
    chk("lw_cnt", {StallCount, FlushCount}, {3'd1, 3'd0});

    // Branch.
    PCSrc_E = 1;
    #1 chk("br_ctl", ctl(), 7'b0000110);
    step();
    idle();
    #1 chk("br_cnt", {StallCount, FlushCount}, {3'd1, 3'd1});

    // Three-cycle memory wait.
    MemReq_M = 1; MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      PCSrc_E = (i == 1);
      #1 chk("mw_ctl", ctl(), 7'b1111001);
      step();
    end
    PCSrc_E = 0; MemReady = 1;
    #1 chk("mw_done", ctl(), 7'b0);
    step();
    idle();
    #1 chk("mw_err", MemErr, 1'b0);
    chk("mw_cnt", {StallCount, FlushCount}, {3'd4, 3'd1});
    MemReq_M = 1; MemReady = 1;
    #1 chk("mw_run", ctl(), 7'b0);
    idle();

    // Timeout: ERR after five low cycles.
    MemReq_M = 1; MemReady = 0;
    for (int i = 0; i < 4; i++) step();
    chk("to_pre", MemErr, 1'b0);
    step();
    chk("to_err", MemErr, 1'b1);
    MemReady = 1; MemReq_M = 0;
    #1 chk("to_frz", ctl(), 7'b1111001);
    step();
    chk("to_stky", MemErr, 1'b1);
    chk("to_sat", StallCount, 3'd7);
    #2 Reset = 1'b1;
    #1 chk("to_rerr", MemErr, 1'b0);
    chk("to_rctl", ctl(), 7'b0);
    chk("to_rcnt", {StallCount, FlushCount}, 6'd0);
    idle();
    @(negedge Clk);
    Reset = 1'b0;
    step();

    // Saturation and clear priority.
    ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
    for (int i = 0; i < 10; i++) step();
    chk("sat7", StallCount, 3'd7);
    CntClear = 1;
    step();
    chk("clr", StallCount, 3'd0);
    CntClear = 0;
    step();
    chk("clr_inc", StallCount, 3'd1);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage RISC-V pipeline. It generates per-stage stall and flush signals for the F/D/E/M/W pipeline registers, where flush drives the Clear input of the decode-to-execute control register. It also produces EX-stage operand forwarding selects and sequences data-memory wait states through a small FSM with a timeout. Two saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive memory wait cycles before error; 0 disables the timeout.
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high
- Rs1_D, Rs2_D  in  5  source registers of the instruction in decode
- Rs1_E, Rs2_E, Rd_E  in  5  source and destination registers in execute
- Rd_M, Rd_W  in  5  destination registers in memory and writeback
- RegWrite_M, RegWrite_W  in  1  register-write enables in memory and writeback
- ResultSrc_E  in  2  result source in execute; 2'b01 = load
- PCSrc_E  in  1  branch taken or jump in execute
- MemReq_M  in  1  load or store in memory stage
- MemReady  in  1  data memory completes the access this cycle
- CntClear  in  1  synchronous clear of both counters
- Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold the stage register
- Flush_D, Flush_E, Flush_W  out  1  insert a bubble into the stage register
- Forward_AE, Forward_BE  out  2  operand select: 00 = regfile, 10 = M-stage ALU result, 01 = W-stage result
- MemErr  out  1  sticky memory-timeout error
- StallCount, FlushCount  out  CNT_W  performance counters

## Operation
- Forwarding, for operand A (B is identical using Rs2_E):
  - Output 10 if RegWrite_M, Rd_M != 0 and Rd_M == Rs1_E.
  - Otherwise 01 if RegWrite_W, Rd_W != 0 and Rd_W == Rs1_E.
  - Otherwise 00. M has priority over W.
- Load-use hazard: lw = (ResultSrc_E == 01) && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D).
- Memory stall: ms = MemReq_M && !MemReady, or state == ERR.
- Outputs when ms = 1:
  - Stall_F, Stall_D, Stall_E and Stall_M = 1.
  - Flush_W = 1.
  - Flush_D and Flush_E = 0; a pending branch in E is held and flushes after the wait.
- Outputs when ms = 0:
  - Stall_F = Stall_D = lw.
  - Flush_E = lw | PCSrc_E.
  - Flush_D = PCSrc_E.
  - Stall_E, Stall_M and Flush_W = 0.
- lw and PCSrc_E are mutually exclusive because a load cannot redirect the PC. The bench asserts this.
- FSM, with states RUN, MWAIT and ERR:
  - RUN: on MemReq_M && !MemReady, go to MWAIT with WaitCnt = 1.
  - MWAIT, MemReady = 1: return to RUN with WaitCnt = 0.
  - MWAIT, MemReady = 0 and TIMEOUT != 0 and WaitCnt == TIMEOUT: go to ERR.
  - MWAIT, otherwise: WaitCnt increments.
  - ERR: held until Reset. MemErr = 1 and the pipeline stays frozen.
- WaitCnt width is clog2(TIMEOUT + 1), minimum 1.
- Counters:
  - StallCount increments on each cycle with Stall_F = 1.
  - FlushCount increments on each cycle with Flush_D = 1.
  - Both saturate at 2^CNT_W − 1.
  - CntClear zeroes both counters and takes priority over increment.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered state, with 0-cycle latency.
- MemErr and the counters are registered and update on the Clk edge after the qualifying cycle.
- Reset values: state RUN, WaitCnt 0, MemErr 0, StallCount 0, FlushCount 0. With all inputs at 0, every stall, flush and forward output is 0.
- Reset asserted during MWAIT or ERR returns to RUN immediately, without waiting for a clock edge.
- A wait of N cycles (MemReady low for N cycles) gives N stall cycles; the access completes in cycle N+1.
- With TIMEOUT = T, ERR is entered on the edge after MemReady has been low for T + 1 consecutive cycles.

## Structure
- Shared package riscv_pipe_pkg holds:
  - ResultSrc encodings (RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10).
  - Forward-select constants (FWD_RF, FWD_W, FWD_M).
  - The FSM state typedef.
- Sub-module pipe_sat_counter (parameter W; inputs Clk, Reset, Clr, Inc; output Count) is instantiated twice, once per performance counter.

## Test plan
- Back-to-back ALU writes to x5, then an instruction reading x5 in E → Forward_AE = 10. Retire one instruction further so only W matches → Forward_AE = 01. Rd = x0 → 00.
- Load to x7 in E with x7 read in D → Stall_F = Stall_D = Flush_E = 1 for exactly one cycle, and StallCount = 1 on the next edge.
- PCSrc_E = 1 for one cycle → Flush_D = Flush_E = 1 and Stall_* = 0, and FlushCount increments by 1.
- MemReq_M = 1 with MemReady low for 3 cycles → Stall_F/D/E/M = 1 and Flush_W = 1 for 3 cycles. The state returns to RUN on the 4th cycle and MemErr stays 0.
- TIMEOUT = 4 with MemReady held low → ERR entered after 5 low cycles, MemErr = 1 sticky. Raising MemReady does not unfreeze; Reset clears everything.
- CNT_W = 3 with 10 stall cycles → StallCount saturates at 7. CntClear asserted together with a stall → StallCount = 0.
